video_pattern_gen: RTL

//  Parametrised video timing generator with a run-time selectable test-pattern source; next generation of the HDMI-path driver.

---
 rtl/video_pattern_gen_if.sv | 29 ++
 rtl/video_pattern_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen_if.sv
// Video source bundle: pattern controls in, timing/coordinates/colour out.
// The generator uses the master side; a pixel sink uses the slave side.
interface video_pattern_gen_if #(
  parameter int CNT_W   = 13,
  parameter int COLOR_W = 8
);
  logic [2:0]           pat_sel;
  logic [3*COLOR_W-1:0] solid_color;
  logic                 video_hs;
  logic                 video_vs;
  logic                 video_de;
  logic [3*COLOR_W-1:0] video_rgb;
  logic [CNT_W-1:0]     pixel_xpos;
  logic [CNT_W-1:0]     pixel_ypos;
  logic                 frame_start;
  logic                 line_start;

  modport master (
    input  pat_sel, solid_color,
    output video_hs, video_vs, video_de, video_rgb,
           pixel_xpos, pixel_ypos, frame_start, line_start
  );

  modport slave (
    output pat_sel, solid_color,
    input  video_hs, video_vs, video_de, video_rgb,
           pixel_xpos, pixel_ypos, frame_start, line_start
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Video timing generator with frame-synchronous test-pattern selection.
// Every output is one register stage after the raster counter state it decodes.
module video_pattern_gen #(
  parameter int         H_SYNC      = 32,
  parameter int         H_BP        = 80,
  parameter int         H_VALID     = 1920,
  parameter int         H_FP        = 48,
  parameter int         V_SYNC      = 5,
  parameter int         V_BP        = 23,
  parameter int         V_VALID     = 1080,
  parameter int         V_FP        = 3,
  parameter bit         HS_POL      = 1'b1,
  parameter bit         VS_POL      = 1'b0,
  parameter int         CNT_W       = 13,
  parameter int         COLOR_W     = 8,
  parameter int         CHK_LOG2    = 5,
  parameter int         MOVE_STEP   = 4,
  parameter logic [2:0] PAT_DEFAULT = 3'd1
) (
  input  logic                pixel_clk,
  input  logic                sys_rst_n,
  video_pattern_gen_if.master vid
);
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int H_TOTAL = H_SYNC + H_BP + H_VALID + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_VALID + V_FP;
  localparam int BAR_W   = $clog2(RGB_W + 1);

  localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_SYNC + H_BP + H_VALID);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_SYNC + V_BP + V_VALID);
  localparam logic [CNT_W-1:0] CB_LAST_C = CNT_W'(H_VALID / 8 - 1);
  localparam logic [CNT_W-1:0] BW_LAST_C = CNT_W'(H_VALID / RGB_W - 1);
  localparam logic [BAR_W-1:0] BW_MAX_C  = BAR_W'(RGB_W);
  localparam logic [RGB_W-1:0] WHITE     = '1;
  localparam logic [RGB_W-1:0] MSB_ONE   = {1'b1, {(RGB_W-1){1'b0}}};

  function automatic logic [RGB_W-1:0] smpte_color(input logic [3:0] idx);
    logic [2:0] m;
    case (idx)
      4'd0:    m = 3'b111;
      4'd1:    m = 3'b110;
      4'd2:    m = 3'b011;
      4'd3:    m = 3'b010;
      4'd4:    m = 3'b101;
      4'd5:    m = 3'b100;
      4'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return {{COLOR_W{m[2]}}, {COLOR_W{m[1]}}, {COLOR_W{m[0]}}};
  endfunction

  logic [CNT_W-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic [CNT_W-1:0] cb_sub_q, cb_sub_d, bw_sub_q, bw_sub_d;
  logic [3:0]       cb_idx_q, cb_idx_d;
  logic [BAR_W-1:0] bw_idx_q, bw_idx_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [2:0]       pat_q;
  logic             run_q;

  logic             hs_q, vs_q, de_q, fs_q, ls_q;
  logic [RGB_W-1:0] rgb_q;
  logic [CNT_W-1:0] x_q, y_q;

  logic             h_last, h_act, v_act, de_cur, frame_cur;
  logic [CNT_W-1:0] x_cur, y_cur;
  logic [CNT_W:0]   pos_sum, mv_end;
  logic             in_bar;
  logic [RGB_W-1:0] rgb_cur;

  always_comb begin
    h_last  = (cnt_h_q == H_LAST_C);
    cnt_h_d = h_last ? '0 : cnt_h_q + 1'b1;
    cnt_v_d = cnt_v_q;
    if (h_last) cnt_v_d = (cnt_v_q == V_LAST_C) ? '0 : cnt_v_q + 1'b1;

    h_act     = (cnt_h_q >= H_START_C) && (cnt_h_q < H_END_C);
    v_act     = (cnt_v_q >= V_START_C) && (cnt_v_q < V_END_C);
    de_cur    = h_act && v_act;
    frame_cur = (cnt_h_q == '0) && (cnt_v_q == '0);
    x_cur     = cnt_h_q - H_START_C;
    y_cur     = cnt_v_q - V_START_C;

    pos_sum = {1'b0, pos_q} + (CNT_W+1)'(MOVE_STEP);
    pos_d   = (pos_sum < (CNT_W+1)'(H_VALID)) ? pos_sum[CNT_W-1:0] : '0;
    mv_end  = {1'b0, pos_q} + (CNT_W+1)'(2 ** CHK_LOG2);
    in_bar  = (x_cur >= pos_q) && ({1'b0, x_cur} < mv_end);
  end

  // Bar sub-counters track the pixel being decoded; any blanking pixel clears them.
  always_comb begin
    cb_sub_d = '0;
    cb_idx_d = '0;
    bw_sub_d = '0;
    bw_idx_d = '0;
    if (h_act) begin
      cb_sub_d = (cb_sub_q == CB_LAST_C) ? '0 : cb_sub_q + 1'b1;
      cb_idx_d = cb_idx_q;
      if (cb_sub_q == CB_LAST_C && cb_idx_q != 4'd8) cb_idx_d = cb_idx_q + 1'b1;
      bw_sub_d = (bw_sub_q == BW_LAST_C) ? '0 : bw_sub_q + 1'b1;
      bw_idx_d = bw_idx_q;
      if (bw_sub_q == BW_LAST_C && bw_idx_q != BW_MAX_C) bw_idx_d = bw_idx_q + 1'b1;
    end
  end

  always_comb begin
    rgb_cur = '0;
    case (pat_q)
      3'd0:    rgb_cur = vid.solid_color;
      3'd1:    rgb_cur = smpte_color(cb_idx_q);
      3'd2:    rgb_cur = {3{x_cur[COLOR_W-1:0]}};
      3'd3:    rgb_cur = (x_cur[CHK_LOG2] ^ y_cur[CHK_LOG2]) ? WHITE : '0;
      3'd4:    rgb_cur = MSB_ONE >> bw_idx_q;
      3'd5:    rgb_cur = in_bar ? WHITE : '0;
      default: rgb_cur = '0;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      cnt_h_q  <= '0;
      cnt_v_q  <= '0;
      cb_sub_q <= '0;
      cb_idx_q <= '0;
      bw_sub_q <= '0;
      bw_idx_q <= '0;
      pos_q    <= '0;
      pat_q    <= PAT_DEFAULT;
      run_q    <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
      rgb_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      cnt_h_q  <= cnt_h_d;
      cnt_v_q  <= cnt_v_d;
      cb_sub_q <= cb_sub_d;
      cb_idx_q <= cb_idx_d;
      bw_sub_q <= bw_sub_d;
      bw_idx_q <= bw_idx_d;
      run_q    <= 1'b1;
      // The frame that follows reset keeps the reset pattern and bar position.
      if (frame_cur && run_q) begin
        pat_q <= vid.pat_sel;
        pos_q <= pos_d;
      end
      hs_q  <= (cnt_h_q < H_SYNC_C) ? HS_POL : ~HS_POL;
      vs_q  <= (cnt_v_q < V_SYNC_C) ? VS_POL : ~VS_POL;
      de_q  <= de_cur;
      fs_q  <= frame_cur;
      ls_q  <= (cnt_h_q == '0);
      rgb_q <= de_cur ? rgb_cur : '0;
      x_q   <= de_cur ? x_cur : '0;
      y_q   <= de_cur ? y_cur : '0;
    end
  end

  assign vid.video_hs    = hs_q;
  assign vid.video_vs    = vs_q;
  assign vid.video_de    = de_q;
  assign vid.video_rgb   = rgb_q;
  assign vid.pixel_xpos  = x_q;
  assign vid.pixel_ypos  = y_q;
  assign vid.frame_start = fs_q;
  assign vid.line_start  = ls_q;
endmodule
